// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control slice.
// Holds the FSM state encoding, the ALUOp / EXTOp / NPC / WDSel codes that
// the alu, ext and npc blocks also decode, the supported opcodes, and the
// one-hot instruction-class layout produced by ctrl_decode.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    // ALU operation codes
    localparam logic [4:0] ALUOP_ADD = 5'b00011;
    localparam logic [4:0] ALUOP_SUB = 5'b00100;
    localparam logic [4:0] ALUOP_OR  = 5'b01101;
    localparam logic [4:0] ALUOP_AND = 5'b01110;

    // One-hot immediate-format selects
    localparam logic [5:0] EXT_I = 6'b010000;
    localparam logic [5:0] EXT_S = 6'b001000;
    localparam logic [5:0] EXT_B = 6'b000100;
    localparam logic [5:0] EXT_J = 6'b000001;

    // Next-PC source selects
    localparam logic [2:0] NPC_PC4    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // Register-file write-data selects
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    // Supported major opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct3 / funct7 values of the supported subset
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One-hot instruction class; exactly one bit is set for a known opcode
    typedef struct packed {
        logic rtype;
        logic ialu;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
    } iclass_t;

    // Loads and stores are the only classes that visit the MEM state
    function automatic logic is_mem_class(input iclass_t c);
        return c.load | c.store;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction classifier.
// Maps the IR opcode/funct fields to a one-hot class, the ALU operation,
// the ALU B-operand select, the immediate format and a legality flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [6:0] cls_o,
    output logic [4:0] alu_op_o,
    output logic       alu_src_b_o,
    output logic [5:0] ext_op_o,
    output logic       legal_o
);

    iclass_t cls;

    // Classify the opcode and check funct fields against the supported subset
    always_comb begin
        cls         = '0;
        alu_op_o    = ALUOP_ADD;
        alu_src_b_o = 1'b0;
        ext_op_o    = '0;
        legal_o     = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                cls.rtype = 1'b1;
                if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        F3_ADD: begin legal_o = 1'b1; alu_op_o = ALUOP_ADD; end
                        F3_OR:  begin legal_o = 1'b1; alu_op_o = ALUOP_OR;  end
                        F3_AND: begin legal_o = 1'b1; alu_op_o = ALUOP_AND; end
                        default: legal_o = 1'b0;
                    endcase
                end else if (funct7_i == F7_ALT && funct3_i == F3_ADD) begin
                    legal_o  = 1'b1;
                    alu_op_o = ALUOP_SUB;
                end
            end
            OP_IALU: begin
                cls.ialu    = 1'b1;
                alu_src_b_o = 1'b1;
                ext_op_o    = EXT_I;
                case (funct3_i)
                    F3_ADD: begin legal_o = 1'b1; alu_op_o = ALUOP_ADD; end
                    F3_OR:  begin legal_o = 1'b1; alu_op_o = ALUOP_OR;  end
                    F3_AND: begin legal_o = 1'b1; alu_op_o = ALUOP_AND; end
                    default: legal_o = 1'b0;
                endcase
            end
            OP_LOAD: begin
                cls.load    = 1'b1;
                alu_src_b_o = 1'b1;
                ext_op_o    = EXT_I;
                legal_o     = (funct3_i == F3_WORD);
            end
            OP_STORE: begin
                cls.store   = 1'b1;
                alu_src_b_o = 1'b1;
                ext_op_o    = EXT_S;
                legal_o     = (funct3_i == F3_WORD);
            end
            OP_BRANCH: begin
                cls.branch = 1'b1;
                alu_op_o   = ALUOP_SUB;
                ext_op_o   = EXT_B;
                legal_o    = (funct3_i == F3_BEQ);
            end
            OP_JAL: begin
                cls.jal  = 1'b1;
                ext_op_o = EXT_J;
                legal_o  = 1'b1;
            end
            OP_JALR: begin
                cls.jalr    = 1'b1;
                alu_src_b_o = 1'b1;
                ext_op_o    = EXT_I;
                legal_o     = (funct3_i == F3_JALR);
            end
            default: legal_o = 1'b0;
        endcase
    end

    assign cls_o = cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I subset
// multicycle datapath sharing one memory port.
// Outputs are combinational from the state and the IR fields; all strobes and
// selects are forced low while rst is high.
// MEM_TIMEOUT > 0 traps after that many unanswered memory wait cycles.
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds cyc_cnt/instret/stall_cnt.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_isel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [2:0]  npc_sel,
    output logic        reg_write,
    output logic [1:0]  wd_sel,
    output logic        alu_src_b,
    output logic [4:0]  alu_op,
    output logic [5:0]  ext_op,
    output logic        illegal,
    output logic        instr_done
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instret,
    output logic [31:0] stall_cnt
`endif
);

    state_e      state_q, state_d;
    logic [6:0]  dec_cls;
    iclass_t     cls;
    logic [4:0]  dec_alu_op;
    logic        dec_alu_src_b;
    logic [5:0]  dec_ext_op;
    logic        dec_legal;
    logic        timeout_hit;

    ctrl_decode u_decode (
        .op_i        (op),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .cls_o       (dec_cls),
        .alu_op_o    (dec_alu_op),
        .alu_src_b_o (dec_alu_src_b),
        .ext_op_o    (dec_ext_op),
        .legal_o     (dec_legal)
    );

    assign cls = iclass_t'(dec_cls);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
            localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

            logic          waiting;
            logic [CW-1:0] wait_q, wait_d;

            assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;

            // Count consecutive unanswered wait cycles; any non-waiting cycle
            // (including leaving FETCH/MEM) restarts the count
            always_comb begin
                wait_d = wait_q;
                if (!waiting) begin
                    wait_d = '0;
                end else if (wait_q != LIMIT) begin
                    wait_d = wait_q + CW'(1);
                end
            end

            // Wait counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    wait_q <= '0;
                end else begin
                    wait_q <= wait_d;
                end
            end

            // A ready in the limit cycle is excluded by waiting, so ready wins
            assign timeout_hit = waiting && (wait_q == LIMIT);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Next-state selection for the instruction sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d = dec_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (cls.rtype || cls.ialu) begin
                    state_d = S_WB;
                end else if (is_mem_class(cls)) begin
                    state_d = S_MEM;
                end else if (cls.branch || cls.jal || cls.jalr) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = cls.store ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // State register; reset abandons any in-flight request and refetches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state strobes and selects, all held low during reset
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_isel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        npc_sel    = NPC_PC4;
        reg_write  = 1'b0;
        wd_sel     = WD_ALU;
        alu_src_b  = 1'b0;
        alu_op     = '0;
        ext_op     = '0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_isel = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        npc_sel  = NPC_PC4;
                    end
                end
                S_DECODE: begin
                    illegal = 1'b0;
                end
                S_EXEC: begin
                    alu_op    = dec_alu_op;
                    alu_src_b = dec_alu_src_b;
                    ext_op    = dec_ext_op;
                    if (cls.branch) begin
                        pc_write   = zero;
                        npc_sel    = NPC_BRANCH;
                        instr_done = 1'b1;
                    end else if (cls.jal || cls.jalr) begin
                        reg_write  = 1'b1;
                        wd_sel     = WD_PC4;
                        pc_write   = 1'b1;
                        npc_sel    = cls.jalr ? NPC_JALR : NPC_JAL;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req    = 1'b1;
                    mem_we     = cls.store;
                    instr_done = mem_ready && cls.store;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    wd_sel     = cls.load ? WD_MEM : WD_ALU;
                    instr_done = 1'b1;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cyc_q, instret_q, stall_q;

    // Free-running performance counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q     <= '0;
            instret_q <= '0;
            stall_q   <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (instr_done) begin
                instret_q <= instret_q + 32'd1;
            end
            if (mem_req && !mem_ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instret   = instret_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle check of the multicycle control
// FSM, plus hand-written timeout sequences on a MEM_TIMEOUT=4 instance.
module tb_multicycle_ctrl;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_OR  = 5'b01101;
    localparam logic [4:0] ALU_AND = 5'b01110;
    localparam logic [5:0] X_I = 6'b010000;
    localparam logic [5:0] X_S = 6'b001000;
    localparam logic [5:0] X_B = 6'b000100;
    localparam logic [5:0] X_J = 6'b000001;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_isel;
        logic       ir_write;
        logic       pc_write;
        logic [2:0] npc_sel;
        logic       reg_write;
        logic [1:0] wd_sel;
        logic       alu_src_b;
        logic [4:0] alu_op;
        logic [5:0] ext_op;
        logic       illegal;
        logic       instr_done;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero;
        logic       rdy;
        outs_t      exp;
        logic       perf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA = 1'b1, rstB = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0000000;
    logic       zero = 1'b0;
    logic       readyA = 1'b0, readyB = 1'b0;

    logic       reqA, weA, iselA, irwA, pcwA, rwA, srcbA, illA, doneA;
    logic [2:0] npcA;
    logic [1:0] wdA;
    logic [4:0] aluA;
    logic [5:0] extA;
    logic       reqB, weB, iselB, irwB, pcwB, rwB, srcbB, illB, doneB;
    logic [2:0] npcB;
    logic [1:0] wdB;
    logic [4:0] aluB;
    logic [5:0] extB;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycA, instA, stallA, cycB, instB, stallB;
`endif

    multicycle_ctrl dutA (
        .clk(clk), .rst(rstA), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(readyA), .mem_req(reqA), .mem_we(weA),
        .mem_isel(iselA), .ir_write(irwA), .pc_write(pcwA), .npc_sel(npcA),
        .reg_write(rwA), .wd_sel(wdA), .alu_src_b(srcbA), .alu_op(aluA),
        .ext_op(extA), .illegal(illA), .instr_done(doneA)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cyc_cnt(cycA), .instret(instA), .stall_cnt(stallA)
`endif
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dutB (
        .clk(clk), .rst(rstB), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(readyB), .mem_req(reqB), .mem_we(weB),
        .mem_isel(iselB), .ir_write(irwB), .pc_write(pcwB), .npc_sel(npcB),
        .reg_write(rwB), .wd_sel(wdB), .alu_src_b(srcbB), .alu_op(aluB),
        .ext_op(extB), .illegal(illB), .instr_done(doneB)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cyc_cnt(cycB), .instret(instB), .stall_cnt(stallB)
`endif
    );

    int    errors = 0;
    int    checks = 0;
    vec_t  vecs[$];
    string names[$];
    logic [6:0] curOp;
    logic [2:0] curF3;
    logic [6:0] curF7;

    // Expected output patterns, written from the cycle-by-cycle behaviour
    function automatic outs_t oFetch(input logic rdy);
        outs_t o = '0;
        o.mem_req  = 1'b1;
        o.mem_isel = 1'b1;
        o.ir_write = rdy;
        o.pc_write = rdy;
        return o;
    endfunction

    function automatic outs_t oExec(input logic [4:0] aop, input logic srcb, input logic [5:0] ext);
        outs_t o = '0;
        o.alu_op    = aop;
        o.alu_src_b = srcb;
        o.ext_op    = ext;
        return o;
    endfunction

    function automatic outs_t oBranch(input logic z);
        outs_t o = oExec(ALU_SUB, 1'b0, X_B);
        o.pc_write   = z;
        o.npc_sel    = 3'b001;
        o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic outs_t oJump(input logic [5:0] ext, input logic srcb, input logic [2:0] npc);
        outs_t o = oExec(ALU_ADD, srcb, ext);
        o.reg_write  = 1'b1;
        o.wd_sel     = 2'b10;
        o.pc_write   = 1'b1;
        o.npc_sel    = npc;
        o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic outs_t oMem(input logic we, input logic done);
        outs_t o = '0;
        o.mem_req    = 1'b1;
        o.mem_we     = we;
        o.instr_done = done;
        return o;
    endfunction

    function automatic outs_t oWb(input logic [1:0] wd);
        outs_t o = '0;
        o.reg_write  = 1'b1;
        o.wd_sel     = wd;
        o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic outs_t oTrap();
        outs_t o = '0;
        o.illegal = 1'b1;
        return o;
    endfunction

    function automatic outs_t sampleA();
        outs_t o;
        o.mem_req = reqA;   o.mem_we = weA;      o.mem_isel = iselA;
        o.ir_write = irwA;  o.pc_write = pcwA;   o.npc_sel = npcA;
        o.reg_write = rwA;  o.wd_sel = wdA;      o.alu_src_b = srcbA;
        o.alu_op = aluA;    o.ext_op = extA;     o.illegal = illA;
        o.instr_done = doneA;
        return o;
    endfunction

    task automatic setInstr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        curOp = o;
        curF3 = f3;
        curF7 = f7;
    endtask

    task automatic addVec(input string nm, input logic r, input logic z, input logic rdy,
                          input outs_t e, input logic pf);
        vec_t v;
        v.rst = r;    v.op = curOp; v.f3 = curF3; v.f7 = curF7;
        v.zero = z;   v.rdy = rdy;  v.exp = e;    v.perf = pf;
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input int i);
        @(negedge clk);
        rstA   = vecs[i].rst;
        op     = vecs[i].op;
        funct3 = vecs[i].f3;
        funct7 = vecs[i].f7;
        zero   = vecs[i].zero;
        readyA = vecs[i].rdy;
        #2;
    endtask

    task automatic stepB(input logic r, input logic rdy);
        @(negedge clk);
        rstB   = r;
        readyB = rdy;
        #2;
    endtask

    initial begin
        // Reset, then add with immediate ready
        setInstr(7'b0110011, 3'b000, 7'b0000000);
        for (int k = 0; k < 3; k++) addVec("reset", 1, 0, 1, '0, 0);
        addVec("add F", 0, 0, 1, oFetch(1), 0);
        addVec("add D", 0, 0, 1, '0, 0);
        addVec("add E", 0, 0, 1, oExec(ALU_ADD, 0, 6'b0), 0);
        addVec("add W", 0, 0, 1, oWb(2'b00), 0);
        // lw with 2 fetch waits and 3 MEM waits
        setInstr(7'b0000011, 3'b010, 7'b0000000);
        addVec("lw F wait", 0, 0, 0, oFetch(0), 0);
        addVec("lw F wait", 0, 0, 0, oFetch(0), 0);
        addVec("lw F rdy", 0, 0, 1, oFetch(1), 0);
        addVec("lw D", 0, 0, 1, '0, 0);
        addVec("lw E", 0, 0, 1, oExec(ALU_ADD, 1, X_I), 0);
        for (int k = 0; k < 3; k++) addVec("lw M wait", 0, 0, 0, oMem(0, 0), 0);
        addVec("lw M rdy", 0, 0, 1, oMem(0, 0), 0);
        addVec("lw W", 0, 0, 1, oWb(2'b01), 0);
        // sw without waits; perf counters sampled on its first cycle
        setInstr(7'b0100011, 3'b010, 7'b0000000);
        addVec("sw F", 0, 0, 1, oFetch(1), 1);
        addVec("sw D", 0, 0, 1, '0, 0);
        addVec("sw E", 0, 0, 1, oExec(ALU_ADD, 1, X_S), 0);
        addVec("sw M rdy", 0, 0, 1, oMem(1, 1), 0);
        // beq taken then not taken
        setInstr(7'b1100011, 3'b000, 7'b0000000);
        addVec("beq1 F", 0, 1, 1, oFetch(1), 0);
        addVec("beq1 D", 0, 1, 1, '0, 0);
        addVec("beq1 E taken", 0, 1, 1, oBranch(1), 0);
        addVec("beq0 F", 0, 0, 1, oFetch(1), 0);
        addVec("beq0 D", 0, 0, 1, '0, 0);
        addVec("beq0 E not taken", 0, 0, 1, oBranch(0), 0);
        // jalr and jal
        setInstr(7'b1100111, 3'b000, 7'b0000000);
        addVec("jalr F", 0, 0, 1, oFetch(1), 0);
        addVec("jalr D", 0, 0, 1, '0, 0);
        addVec("jalr E", 0, 0, 1, oJump(X_I, 1, 3'b100), 0);
        setInstr(7'b1101111, 3'b101, 7'b1010101);
        addVec("jal F", 0, 0, 1, oFetch(1), 0);
        addVec("jal D", 0, 0, 1, '0, 0);
        addVec("jal E", 0, 0, 1, oJump(X_J, 0, 3'b010), 0);
        // Other ALU forms
        setInstr(7'b0110011, 3'b000, 7'b0100000);
        addVec("sub F", 0, 0, 1, oFetch(1), 0);
        addVec("sub D", 0, 0, 1, '0, 0);
        addVec("sub E", 0, 0, 1, oExec(ALU_SUB, 0, 6'b0), 0);
        addVec("sub W", 0, 0, 1, oWb(2'b00), 0);
        setInstr(7'b0010011, 3'b110, 7'b1111111);
        addVec("ori F", 0, 0, 1, oFetch(1), 0);
        addVec("ori D", 0, 0, 1, '0, 0);
        addVec("ori E", 0, 0, 1, oExec(ALU_OR, 1, X_I), 0);
        addVec("ori W", 0, 0, 1, oWb(2'b00), 0);
        setInstr(7'b0110011, 3'b111, 7'b0000000);
        addVec("and F", 0, 0, 1, oFetch(1), 0);
        addVec("and D", 0, 0, 1, '0, 0);
        addVec("and E", 0, 0, 1, oExec(ALU_AND, 0, 6'b0), 0);
        addVec("and W", 0, 0, 1, oWb(2'b00), 0);
        // Unsupported opcode traps, stays trapped, reset clears
        setInstr(7'b0110111, 3'b000, 7'b0000000);
        addVec("lui F", 0, 0, 1, oFetch(1), 0);
        addVec("lui D", 0, 0, 1, '0, 0);
        addVec("trap 1", 0, 0, 1, oTrap(), 0);
        addVec("trap 2 sticky", 0, 1, 1, oTrap(), 0);
        addVec("trap rst", 1, 0, 1, '0, 0);
        // Bad funct7 on an R-type also traps
        setInstr(7'b0110011, 3'b000, 7'b0000001);
        addVec("badf7 F", 0, 0, 1, oFetch(1), 0);
        addVec("badf7 D", 0, 0, 1, '0, 0);
        addVec("badf7 trap", 0, 0, 1, oTrap(), 0);
        addVec("badf7 rst", 1, 0, 1, '0, 0);
        // Reset during the MEM wait of a store
        setInstr(7'b0100011, 3'b010, 7'b0000000);
        addVec("swr F", 0, 0, 1, oFetch(1), 0);
        addVec("swr D", 0, 0, 1, '0, 0);
        addVec("swr E", 0, 0, 1, oExec(ALU_ADD, 1, X_S), 0);
        addVec("swr M wait", 0, 0, 0, oMem(1, 0), 0);
        addVec("swr rst in M", 1, 0, 0, '0, 0);
        addVec("swr after rst F", 0, 0, 0, oFetch(0), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
            checkOutput(names[i], 32'(sampleA()), 32'(vecs[i].exp));
`ifdef MULTICYCLE_CTRL_PERF_EN
            if (vecs[i].perf) begin
                checkOutput("perf instret", instA, 32'd2);
                checkOutput("perf stall_cnt", stallA, 32'd5);
                checkOutput("perf cyc_cnt", cycA, 32'd14);
            end
`endif
        end

        // Timeout instance: 4 unanswered fetch cycles trap
        rstA = 1'b1;
        op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
        stepB(1, 0);
        for (int k = 0; k < 4; k++) begin
            stepB(0, 0);
            checkOutput("tmo wait req", {30'd0, reqB, illB}, 32'b10);
        end
        stepB(0, 0);
        checkOutput("tmo trapped", {29'd0, illB, reqB, irwB}, 32'b100);
        stepB(0, 1);
        checkOutput("tmo sticky", {29'd0, illB, reqB, irwB}, 32'b100);
`ifdef MULTICYCLE_CTRL_PERF_EN
        checkOutput("tmo stall_cnt", stallB, 32'd4);
`endif
        // Ready arriving in the limit cycle wins over the timeout
        stepB(1, 0);
        checkOutput("tmo rst clears", {31'd0, illB}, 32'b0);
        for (int k = 0; k < 3; k++) stepB(0, 0);
        stepB(0, 1);
        checkOutput("ready wins irw", {30'd0, irwB, illB}, 32'b10);
        stepB(0, 1);
        checkOutput("ready wins decode", {30'd0, illB, reqB}, 32'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I subset datapath: add/sub/or/and, addi/ori/andi, lw, sw, beq, jal, jalr.
- Sequences one shared memory port, the IR, PC, register file and ALU over FETCH/DECODE/EXEC/MEM/WB.
- Sits beside the datapath in place of the single-cycle decoder. Consumes IR fields and the ALU zero flag; drives per-cycle strobes and mux selects.

Parameters:
- MEM_TIMEOUT, 0, max wait cycles on mem_ready before trapping; 0 = wait forever.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory accepted/completed the current request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- mem_isel  out  1  1 = address from PC (fetch), 0 = from ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from the npc_sel source
- npc_sel  out  3  000 PC+4, 001 branch, 010 jal, 100 jalr
- reg_write  out  1  register-file write strobe
- wd_sel  out  2  00 ALU, 01 MDR, 10 PC+4
- alu_src_b  out  1  1 = immediate
- alu_op  out  5  same encoding as the ALUOp table (add 00011, sub 00100, or 01101, and 01110)
- ext_op  out  6  one-hot immediate-format select, same encoding as EXTOp
- illegal  out  1  sticky trap flag
- instr_done  out  1  one-cycle pulse on each retiring cycle

Behaviour:
- State register: FETCH, DECODE, EXEC, MEM, WB, TRAP (3-bit encoding in the package). rst → FETCH, illegal=0.
- While rst=1, all strobes are 0: mem_req, mem_we, ir_write, pc_write, reg_write, instr_done. Selects are 0.
- Outputs are combinational from state plus op/funct fields (Moore on state); no output register.
- FETCH:
  - mem_req=1, mem_isel=1, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, npc_sel=000, → DECODE.
  - Without mem_ready: remain; no strobes except mem_req.
- DECODE: classify op/funct3/funct7.
  - Unsupported encoding → TRAP.
  - Otherwise → EXEC. No strobes.
- EXEC: alu_op and alu_src_b set by class.
  - R-type and I-ALU → WB.
  - lw/sw: ALU computes the address → MEM.
  - beq: alu_op=sub; pc_write=zero, npc_sel=001; instr_done=1 → FETCH.
  - jal/jalr: reg_write=1, wd_sel=10, pc_write=1, npc_sel=010 or 100; instr_done=1 → FETCH.
- MEM: mem_req=1, mem_isel=0, mem_we=(sw).
  - On mem_ready: sw sets instr_done=1 → FETCH; lw → WB.
- WB: reg_write=1, wd_sel=01 for lw, 00 otherwise; instr_done=1 → FETCH.
- Latencies without wait states: R/I 4, lw 5, sw 4, beq 3, jal/jalr 3 cycles.
- mem_req, mem_isel and mem_we stay stable while waiting. mem_ready outside FETCH/MEM is ignored.
- MEM_TIMEOUT>0: a wait counter resets on entry to FETCH/MEM and saturates.
  - Reaching MEM_TIMEOUT without mem_ready → TRAP.
  - If mem_ready arrives in the same cycle the counter hits the limit, the ready wins.
- TRAP: illegal=1, all strobes 0. Held until rst.
- Reset mid-request: the request is dropped next edge; the memory must tolerate an abandoned request.
- rd=x0 filtering is the register file's job, not this block's.

Optional Feature:
- MULTICYCLE_CTRL_PERF_EN: adds outputs cyc_cnt[31:0] (cycles since reset), instret[31:0] (instr_done count) and stall_cnt[31:0] (cycles with mem_req=1 and mem_ready=0).
  - All counters wrap modulo 2^32 and clear on rst.
- Without the macro these ports and counters do not exist.

Decomposition:
- Package ctrl_pkg:
  - state encodings
  - ALUOp, EXTOp, NPC and WDSel constants (shared with alu/ext/npc)
  - opcode constants: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111
- Sub-module ctrl_decode: purely combinational op/funct → class one-hot, alu_op, ext_op, legal.
- The FSM and timeout counter stay in multicycle_ctrl.

Test Plan:
- rst 3 cycles, then add (op 0110011, f3 000, f7 0000000) with mem_ready=1 at once → states F,D,E,W; reg_write=1, wd_sel=00 in cycle 4; instr_done once.
- lw with 2-cycle fetch wait and 3-cycle MEM wait → mem_req held high 3+4 cycles, ir_write only on the ready cycle; WB wd_sel=01; total 10 cycles.
- beq with zero=1, then zero=0 → pc_write=1/npc_sel=001 in EXEC, then pc_write=0; each retires in 3 cycles.
- jalr (1100111) → EXEC cycle: reg_write=1, wd_sel=10, pc_write=1, npc_sel=100, ext_op=010000.
- op=0110111 (unsupported) → TRAP after DECODE, illegal=1 sticky, no strobes; rst clears. With MEM_TIMEOUT=4 and mem_ready=0 in FETCH → TRAP on the 4th wait cycle.
- rst asserted during MEM of sw → next cycle all strobes 0, state FETCH. With MULTICYCLE_CTRL_PERF_EN after 2 instructions: instret=2, stall_cnt equals the injected wait cycles.
